lcd_cmd_arbiter: RTL and testbench
==================================

# lcd_cmd_arbiter

Shares the Spartan-3E character LCD 4-bit bus between two independent command/data requesters once power-on initialisation has completed. Each granted 8-bit transfer is sequenced as upper nibble, then lower nibble on SF_D[11:8], with LCD_E pulse widths, inter-nibble gap and post-command wait generated from clk cycles. It sits between the application-level writers (a status-line writer and a message writer) and the LCD output mux. It is enabled by the initialisation FSM's done/enable flag.

## Interface
- T_SETUP, 2: cycles data/RS are stable before LCD_E rises (40 ns at 50 MHz)
- T_E, 12: LCD_E high cycles (240 ns)
- T_HOLD, 1: cycles data held after LCD_E falls
- T_GAP, 50: cycles between the end of the upper-nibble hold and the start of the lower-nibble setup (1 us)
- T_WAIT, 2000: cycles after the lower-nibble hold before the next grant (40 us)
- CNT_W, 12: phase counter width; must hold max(T_*)
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low reset
- init_done  in  1  high once LCD initialisation has finished; grants are blocked while low
- req0, req1  in  1  request from requester 0/1; held high until acked
- rs0, rs1  in  1  register select for the pending byte (0 = command, 1 = data)
- data0, data1  in  8  byte to transfer; stable while req high
- ack0, ack1  out  1  one-cycle grant pulse; the byte is captured
- busy  out  1  high from grant until return to IDLE
- SF_D  out  12  [11:8] = current nibble, [7:0] = 0
- LCD_E  out  1  enable strobe
- LCD_RS  out  1  latched rs of the granted requester
- LCD_RW  out  1  tied 0 (write only)

## Operation
- States: IDLE, HI_SETUP, HI_PULSE, HI_HOLD, GAP, LO_SETUP, LO_PULSE, LO_HOLD, WAIT.
- Phase lengths:
  - HI_SETUP and LO_SETUP last T_SETUP cycles.
  - HI_PULSE and LO_PULSE last T_E cycles.
  - HI_HOLD and LO_HOLD last T_HOLD cycles.
  - GAP lasts T_GAP cycles.
  - WAIT lasts T_WAIT cycles.
- Phase counter: loads 0 on state entry and advances to the next state when it reaches length−1.
- IDLE grant:
  - Arbitration is evaluated only when init_done = 1 and (req0 | req1).
  - Winner: if only one requester is asserting req, it wins. If both are, round-robin: pointer `last` selects the requester not granted most recently.
  - On grant: latch data/rs into byte_q/rs_q, pulse ack of the winner, set busy, update `last`, go to HI_SETUP.
- SF_D[11:8] = byte_q[7:4] in HI_* states and byte_q[3:0] in LO_* states. SF_D is 0 in IDLE, GAP and WAIT.
- LCD_E = 1 only in HI_PULSE and LO_PULSE.
- LCD_RS = rs_q in all non-IDLE states, 0 in IDLE.
- Requests arriving during busy are not acked and are evaluated in the IDLE cycle after WAIT.
- A req dropped before being sampled in IDLE produces no transfer and no ack.
- If init_done falls mid-transfer, the current transfer completes. No new grant is issued while init_done is low.
- All outputs are registered (glitch-free LCD_E).

## Timing
- Reset (asynchronous, active-low): state = IDLE; SF_D = 0, LCD_E = 0, LCD_RS = 0, LCD_RW = 0, ack0/1 = 0, busy = 0, `last` = 1 (requester 0 favoured first).
- Reset asserted mid-transfer: all outputs go to their reset values immediately. The transfer is abandoned and is not re-issued.
- Grant latency: req sampled high at edge N (in IDLE, init_done = 1) → ack and busy high after edge N. The first HI_SETUP cycle is the cycle after edge N. ack stays high for exactly one cycle.
- Transfer length from first HI_SETUP cycle to return to IDLE: 2·(T_SETUP+T_E+T_HOLD)+T_GAP+T_WAIT = 2080 cycles with defaults.
- Minimum grant-to-grant spacing for back-to-back requests is 2081 cycles: the transfer plus one IDLE cycle.
- LCD_E rises T_SETUP cycles after nibble data changes and falls T_HOLD cycles before it changes.

## Test plan
- Single write: reset released, init_done = 1, req0 with rs0 = 1, data0 = 0x41.
  - ack0 pulses one cycle.
  - SF_D[11:8] = 0x4 with LCD_E high for 12 cycles.
  - 50 cycles after the upper-nibble hold, SF_D[11:8] = 0x1 with LCD_E high for 12 cycles.
  - LCD_RS = 1 throughout the transfer.
  - busy high for 2080 cycles; LCD_RW = 0 always.
- Simultaneous requests: req0 (0x80, rs = 0) and req1 (0x42, rs = 1) both held from reset.
  - req0 granted first, req1 granted 2081 cycles later.
  - req0 re-asserted together with req1 → req0 wins the next arbitration, because req1 was granted last.
- Gated by init_done: init_done = 0 with req1 held for 5000 cycles → no ack, LCD_E stays 0. Raising init_done → ack1 on the next cycle.
- Request while busy: req1 asserted during req0's GAP → ack1 only in the IDLE cycle after WAIT. Its bytes appear unchanged.
- Reset mid-transfer: reset asserted during HI_PULSE → LCD_E, SF_D and busy drop to 0 without waiting for a clock edge. After release, with no req, the bus stays idle.
- Back-to-back single requester: req0 held continuously with data0 changing at each ack → every byte is transferred exactly once, with acks 2081 cycles apart.

Source files
------------

// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: shares the Spartan-3E character LCD 4-bit bus between two
// command/data requesters once LCD initialisation is done. Each granted byte is
// sent as upper nibble then lower nibble on SF_D[11:8]. LCD_E pulse widths,
// the inter-nibble gap and the post-command wait are all counted in clk cycles.
// Every output comes straight from a flop, so LCD_E cannot glitch.
`timescale 1ns/1ps
module lcd_cmd_arbiter #(
  parameter int T_SETUP = 2,     // data/RS stable before LCD_E rises
  parameter int T_E     = 12,    // LCD_E high time
  parameter int T_HOLD  = 1,     // data held after LCD_E falls
  parameter int T_GAP   = 50,    // gap between upper-nibble hold and lower-nibble setup
  parameter int T_WAIT  = 2000,  // settle time after the lower nibble before the next grant
  parameter int CNT_W   = 12     // phase counter width, must hold the largest T_* value
) (
  input  logic        clk,
  input  logic        reset,     // asynchronous, active-low
  input  logic        init_done,
  input  logic        req0,
  input  logic        req1,
  input  logic        rs0,
  input  logic        rs1,
  input  logic [7:0]  data0,
  input  logic [7:0]  data1,
  output logic        ack0,
  output logic        ack1,
  output logic        busy,
  output logic [11:0] SF_D,
  output logic        LCD_E,
  output logic        LCD_RS,
  output logic        LCD_RW
);

  typedef enum logic [3:0] {
    IDLE,
    HI_SETUP,
    HI_PULSE,
    HI_HOLD,
    GAP,
    LO_SETUP,
    LO_PULSE,
    LO_HOLD,
    WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             rs_q, rs_d;
  logic             last_q, last_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q, busy_d;
  logic             lcd_e_q, lcd_e_d;
  logic             lcd_rs_q, lcd_rs_d;
  logic [3:0]       nib_q, nib_d;

  logic [CNT_W-1:0] phase_last;
  logic             phase_end;
  logic             pick1;

  // Last counter value of the phase currently being timed.
  always_comb begin
    phase_last = '0;
    case (state_q)
      HI_SETUP, LO_SETUP: phase_last = CNT_W'(T_SETUP - 1);
      HI_PULSE, LO_PULSE: phase_last = CNT_W'(T_E - 1);
      HI_HOLD,  LO_HOLD:  phase_last = CNT_W'(T_HOLD - 1);
      GAP:                phase_last = CNT_W'(T_GAP - 1);
      WAIT:               phase_last = CNT_W'(T_WAIT - 1);
      default:            phase_last = '0;
    endcase
  end

  assign phase_end = (cnt_q == phase_last);

  // Round-robin pick: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    pick1 = 1'b0;
    if (req0 && req1) begin
      pick1 = ~last_q;
    end else begin
      pick1 = req1;
    end
  end

  // Next-state logic, grant capture, and the next value of every registered output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    byte_d  = byte_q;
    rs_d    = rs_q;
    last_d  = last_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (init_done && (req0 || req1)) begin
          if (pick1) begin
            byte_d = data1;
            rs_d   = rs1;
            ack1_d = 1'b1;
          end else begin
            byte_d = data0;
            rs_d   = rs0;
            ack0_d = 1'b1;
          end
          last_d  = pick1;
          state_d = HI_SETUP;
        end
      end
      default: begin
        if (phase_end) begin
          cnt_d = '0;
          case (state_q)
            HI_SETUP: state_d = HI_PULSE;
            HI_PULSE: state_d = HI_HOLD;
            HI_HOLD:  state_d = GAP;
            GAP:      state_d = LO_SETUP;
            LO_SETUP: state_d = LO_PULSE;
            LO_PULSE: state_d = LO_HOLD;
            LO_HOLD:  state_d = WAIT;
            default:  state_d = IDLE;
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase

    // Outputs are decoded from the state being entered so they line up with it.
    busy_d   = (state_d != IDLE);
    lcd_e_d  = (state_d == HI_PULSE) || (state_d == LO_PULSE);
    lcd_rs_d = (state_d != IDLE) ? rs_d : 1'b0;
    case (state_d)
      HI_SETUP, HI_PULSE, HI_HOLD: nib_d = byte_d[7:4];
      LO_SETUP, LO_PULSE, LO_HOLD: nib_d = byte_d[3:0];
      default:                     nib_d = 4'h0;
    endcase
  end

  // State, phase counter, captured byte and registered outputs; reset abandons any transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      byte_q   <= 8'h00;
      rs_q     <= 1'b0;
      last_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      busy_q   <= 1'b0;
      lcd_e_q  <= 1'b0;
      lcd_rs_q <= 1'b0;
      nib_q    <= 4'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      rs_q     <= rs_d;
      last_q   <= last_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      busy_q   <= busy_d;
      lcd_e_q  <= lcd_e_d;
      lcd_rs_q <= lcd_rs_d;
      nib_q    <= nib_d;
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign busy   = busy_q;
  assign SF_D   = {nib_q, 8'h00};
  assign LCD_E  = lcd_e_q;
  assign LCD_RS = lcd_rs_q;
  assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// tb_lcd_cmd_arbiter: directed test of the two-requester LCD bus arbiter.
// Outputs are sampled on the falling clock edge; inputs change there too.
`timescale 1ns/1ps
module tb_lcd_cmd_arbiter;

  localparam int T_SETUP = 2;
  localparam int T_E     = 12;
  localparam int T_HOLD  = 1;
  localparam int T_GAP   = 50;
  localparam int T_WAIT  = 2000;

  // Cycle offsets from the first HI_SETUP cycle (k = 0) of a transfer.
  localparam int HI_E_START = T_SETUP;                 // 2
  localparam int HI_E_END   = HI_E_START + T_E;        // 14, exclusive
  localparam int HI_END     = HI_E_END + T_HOLD;       // 15, exclusive
  localparam int LO_START   = HI_END + T_GAP;          // 65
  localparam int LO_E_START = LO_START + T_SETUP;      // 67
  localparam int LO_E_END   = LO_E_START + T_E;        // 79, exclusive
  localparam int LO_END     = LO_E_END + T_HOLD;       // 80, exclusive
  localparam int XFER_LEN   = LO_END + T_WAIT;         // 2080

  logic        clk;
  logic        reset;
  logic        init_done;
  logic        req0, req1, rs0, rs1;
  logic [7:0]  data0, data1;
  logic        ack0, ack1, busy;
  logic [11:0] SF_D;
  logic        LCD_E, LCD_RS, LCD_RW;

  int totalCount = 0;
  int badCount   = 0;

  lcd_cmd_arbiter #(
    .T_SETUP(T_SETUP),
    .T_E(T_E),
    .T_HOLD(T_HOLD),
    .T_GAP(T_GAP),
    .T_WAIT(T_WAIT),
    .CNT_W(12)
  ) dut (
    .clk(clk),
    .reset(reset),
    .init_done(init_done),
    .req0(req0),
    .req1(req1),
    .rs0(rs0),
    .rs1(rs1),
    .data0(data0),
    .data1(data1),
    .ack0(ack0),
    .ack1(ack1),
    .busy(busy),
    .SF_D(SF_D),
    .LCD_E(LCD_E),
    .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW)
  );

  // 50 MHz clock.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Hard stop in case something wedges beyond every bounded wait.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts it and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCount++;
    if (got !== exp) begin
      badCount++;
      $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drives all requester inputs at once.
  task automatic applyStimulus(input logic r0, input logic s0, input logic [7:0] d0,
                               input logic r1, input logic s1, input logic [7:0] d1);
    req0  = r0;
    rs0   = s0;
    data0 = d0;
    req1  = r1;
    rs1   = s1;
    data1 = d1;
  endtask

  // Waits (bounded) for the ack of one requester; expects it one cycle after the call.
  task automatic waitAck(input int who, input string tag);
    int   waited;
    logic seen;
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 3000) begin
      @(negedge clk);
      waited++;
      seen = (who == 0) ? ack0 : ack1;
    end
    checkOutput({tag, "_ack"}, 32'(seen), 1);
    checkOutput({tag, "_latency"}, 32'(waited), 1);
  endtask

  // Called on the sample of the first HI_SETUP cycle; follows the whole transfer
  // up to and including the IDLE cycle after WAIT.
  task automatic checkTransfer(input logic [7:0] b, input logic rs, input int who, input string tag);
    int         badCycles;
    int         eCycles;
    int         busyCycles;
    int         firstBad;
    logic [17:0] obs, exp;
    logic       expA0, expA1, expBusy, expE, expRs;
    logic [3:0] expNib;
    badCycles  = 0;
    eCycles    = 0;
    busyCycles = 0;
    firstBad   = -1;
    for (int k = 0; k <= XFER_LEN; k++) begin
      if (k > 0) @(negedge clk);
      expA0   = (who == 0) && (k == 0);
      expA1   = (who == 1) && (k == 0);
      expBusy = (k < XFER_LEN);
      expE    = ((k >= HI_E_START) && (k < HI_E_END)) || ((k >= LO_E_START) && (k < LO_E_END));
      expRs   = (k < XFER_LEN) ? rs : 1'b0;
      if (k < HI_END)                         expNib = b[7:4];
      else if ((k >= LO_START) && (k < LO_END)) expNib = b[3:0];
      else                                    expNib = 4'h0;
      obs = {ack0, ack1, busy, SF_D, LCD_E, LCD_RS, LCD_RW};
      exp = {expA0, expA1, expBusy, expNib, 8'h00, expE, expRs, 1'b0};
      if (obs !== exp) begin
        badCycles++;
        if (firstBad < 0) begin
          firstBad = k;
          $display("[TB] %s first deviation at k=%0d obs=0x%05h exp=0x%05h", tag, k, obs, exp);
        end
      end
      if (LCD_E) eCycles++;
      if (busy)  busyCycles++;
    end
    checkOutput({tag, "_bad_cycles"}, 32'(badCycles), 0);
    checkOutput({tag, "_e_cycles"}, 32'(eCycles), 32'(2 * T_E));
    checkOutput({tag, "_busy_cycles"}, 32'(busyCycles), 32'(XFER_LEN));
  endtask

  // Watches the bus for a number of cycles and expects no activity at all.
  task automatic watchIdle(input int cycles, input string tag);
    int activity;
    activity = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (ack0 || ack1 || busy || LCD_E || LCD_RS || LCD_RW || (SF_D != 12'h000)) activity++;
    end
    checkOutput(tag, 32'(activity), 0);
  endtask

  // Main directed sequence.
  initial begin
    reset     = 1'b0;
    init_done = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Reset values.
    repeat (3) @(negedge clk);
    checkOutput("rst_sfd", 32'(SF_D), 0);
    checkOutput("rst_e", 32'(LCD_E), 0);
    checkOutput("rst_rs", 32'(LCD_RS), 0);
    checkOutput("rst_rw", 32'(LCD_RW), 0);
    checkOutput("rst_acks", 32'({ack0, ack1}), 0);
    checkOutput("rst_busy", 32'(busy), 0);

    // Single write 0x41 as data from requester 0.
    reset     = 1'b1;
    init_done = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle_busy", 32'(busy), 0);
    applyStimulus(1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
    waitAck(0, "single");
    applyStimulus(1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00);
    checkTransfer(8'h41, 1'b1, 0, "single");
    watchIdle(10, "single_after");

    // Simultaneous requests held through reset: requester 0 is favoured first.
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h80, 1'b1, 1'b1, 8'h42);
    @(negedge clk);
    reset = 1'b1;
    waitAck(0, "both_r0");
    applyStimulus(1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 8'h42);
    checkTransfer(8'h80, 1'b0, 0, "both_r0");
    waitAck(1, "both_r1");
    applyStimulus(1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h99);
    checkTransfer(8'h42, 1'b1, 1, "both_r1");
    waitAck(0, "rr_r0");
    applyStimulus(1'b0, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h99);
    checkTransfer(8'hC3, 1'b0, 0, "rr_r0");
    waitAck(1, "rr_r1");
    applyStimulus(1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 8'h99);
    checkTransfer(8'h99, 1'b1, 1, "rr_r1");

    // Gated by init_done, then init_done dropped mid-transfer.
    init_done = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h5A);
    begin
      int activity;
      activity = 0;
      for (int i = 0; i < 5000; i++) begin
        @(negedge clk);
        if (ack0 || ack1 || busy || LCD_E) activity++;
      end
      checkOutput("gated_activity", 32'(activity), 0);
    end
    init_done = 1'b1;
    waitAck(1, "gated_r1");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A);
    fork
      begin
        repeat (100) @(negedge clk);
        init_done = 1'b0;
        repeat (400) @(negedge clk);
        init_done = 1'b1;
      end
    join_none
    checkTransfer(8'h5A, 1'b0, 1, "gated_r1");

    // Request from requester 1 raised during requester 0's GAP.
    applyStimulus(1'b1, 1'b1, 8'h27, 1'b0, 1'b0, 8'h00);
    waitAck(0, "busy_r0");
    applyStimulus(1'b0, 1'b1, 8'h27, 1'b0, 1'b0, 8'h00);
    fork
      begin
        repeat (30) @(negedge clk);
        req1  = 1'b1;
        rs1   = 1'b0;
        data1 = 8'hE8;
      end
    join_none
    checkTransfer(8'h27, 1'b1, 0, "busy_r0");
    waitAck(1, "busy_r1");
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hE8);
    checkTransfer(8'hE8, 1'b0, 1, "busy_r1");

    // Asynchronous reset in the middle of HI_PULSE.
    applyStimulus(1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 8'h00);
    waitAck(0, "rst_mid");
    applyStimulus(1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 8'h00);
    repeat (5) @(negedge clk);
    checkOutput("rst_mid_pre_e", 32'(LCD_E), 1);
    checkOutput("rst_mid_pre_sfd", 32'(SF_D), 32'h00000F00);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_e", 32'(LCD_E), 0);
    checkOutput("rst_mid_sfd", 32'(SF_D), 0);
    checkOutput("rst_mid_busy", 32'(busy), 0);
    checkOutput("rst_mid_rs", 32'(LCD_RS), 0);
    @(negedge clk);
    reset = 1'b1;
    watchIdle(3000, "rst_mid_after");

    // Back-to-back transfers from requester 0 with the byte changing at each ack.
    applyStimulus(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00);
    waitAck(0, "b2b_1");
    applyStimulus(1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 8'h00);
    checkTransfer(8'h11, 1'b0, 0, "b2b_1");
    waitAck(0, "b2b_2");
    applyStimulus(1'b1, 1'b0, 8'h33, 1'b0, 1'b0, 8'h00);
    checkTransfer(8'h22, 1'b1, 0, "b2b_2");
    waitAck(0, "b2b_3");
    applyStimulus(1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 8'h00);
    checkTransfer(8'h33, 1'b0, 0, "b2b_3");
    watchIdle(20, "b2b_after");

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
